// File: rtl/fifo_pi_stream_if.sv
// Handshake/bus bundle between a parallel-lane producer, fifo_pi_stream and its serial consumer.
interface fifo_pi_stream_if #(
  parameter int WIDTH = 16,
  parameter int NLANE = 9,
  parameter int DEPTH = 2*NLANE+1
);
  logic [WIDTH*NLANE-1:0]       DI;
  logic [$clog2(NLANE+1)-1:0]   DI_CNT;
  logic                         WRITE;
  logic                         WREADY;
  logic [WIDTH-1:0]             DO;
  logic                         READ;
  logic                         EMPTY;
  logic                         FULL;
  logic [$clog2(DEPTH+1)-1:0]   LEVEL;
  logic                         AFULL;
  logic                         AEMPTY;

  modport master (
    output DI, DI_CNT, WRITE, READ,
    input  WREADY, DO, EMPTY, FULL, LEVEL, AFULL, AEMPTY
  );

  modport slave (
    input  DI, DI_CNT, WRITE, READ,
    output WREADY, DO, EMPTY, FULL, LEVEL, AFULL, AEMPTY
  );
endinterface

// File: rtl/fifo_pi_stream.sv
// Parallel-in / serial-out FWFT FIFO: a stager drains a 1..NLANE lane vector into storage one word per cycle.
// Optional sticky overflow/underflow ERR output enabled by defining FIFO_PI_STREAM_ERR_EN.
module fifo_pi_stream #(
  parameter int WIDTH     = 16,
  parameter int NLANE     = 9,
  parameter int DEPTH     = 2*NLANE+1,
  parameter int AFULL_TH  = DEPTH-2,
  parameter int AEMPTY_TH = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
`ifdef FIFO_PI_STREAM_ERR_EN
  output logic [1:0] ERR,
`endif
  fifo_pi_stream_if.slave bus
);
  localparam int CW = $clog2(NLANE+1);
  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LV_DEPTH  = LW'(DEPTH);
  localparam logic [LW-1:0] LV_AFULL  = LW'(AFULL_TH);
  localparam logic [LW-1:0] LV_AEMPTY = LW'(AEMPTY_TH);
  localparam logic [AW-1:0] A_LAST    = AW'(DEPTH-1);
  localparam logic [CW-1:0] C_NLANE   = CW'(NLANE);

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH*NLANE-1:0]   stage_q, stage_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            idx_q, idx_d;
  logic [AW-1:0]            head_q, head_d;
  logic [AW-1:0]            tail_q, tail_d;
  logic [LW-1:0]            level_q, level_d;
  logic [WIDTH-1:0]         do_q, do_d;
  logic [WIDTH-1:0]         mem [DEPTH];

  logic             push, pop, last, wready, accept;
  logic [WIDTH-1:0] lane;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    do_d    = do_q;

    // The staged vector shifts down one lane per push, so the current lane is always lane 0.
    lane   = stage_q[WIDTH-1:0];
    push   = (state_q == ST_DRAIN) && (level_q != LV_DEPTH);
    pop    = bus.READ && (level_q != '0);
    last   = (idx_q == cnt_q - CW'(1));
    wready = (state_q == ST_IDLE) || (last && push);
    accept = bus.WRITE && wready && (bus.DI_CNT != '0);

    if (EN) begin
      if (push) begin
        tail_d  = (tail_q == A_LAST) ? '0 : tail_q + AW'(1);
        stage_d = stage_q >> WIDTH;
        if (last) state_d = ST_IDLE;
        else      idx_d   = idx_q + CW'(1);
      end
      if (pop) head_d = (head_q == A_LAST) ? '0 : head_q + AW'(1);
      if (accept) begin
        state_d = ST_DRAIN;
        stage_d = bus.DI;
        cnt_d   = (bus.DI_CNT > C_NLANE) ? C_NLANE : bus.DI_CNT;
        idx_d   = '0;
      end
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);
      // The word landing at the new head is not in mem yet; forward it.
      do_d = (push && (tail_q == head_d)) ? lane : mem[head_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      do_q    <= do_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && EN && push) mem[tail_q] <= lane;
  end

`ifdef FIFO_PI_STREAM_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (EN) begin
      if (bus.WRITE && !wready)       err_d[0] = 1'b1;
      if (bus.READ && level_q == '0)  err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) err_q <= '0;
    else       err_q <= err_d;
  end

  assign ERR = err_q;
`endif

  assign bus.WREADY = wready;
  assign bus.DO     = do_q;
  assign bus.EMPTY  = (level_q == '0);
  assign bus.FULL   = (level_q == LV_DEPTH);
  assign bus.LEVEL  = level_q;
  assign bus.AFULL  = (level_q >= LV_AFULL);
  assign bus.AEMPTY = (level_q <= LV_AEMPTY);
endmodule

// File: tb/tb_fifo_pi_stream.sv
// Self-checking bench for fifo_pi_stream: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_pi_stream;
  localparam int WIDTH     = 16;
  localparam int NLANE     = 9;
  localparam int DEPTH     = 2*NLANE+1;
  localparam int AFULL_TH  = DEPTH-2;
  localparam int AEMPTY_TH = 1;
  localparam int CW        = $clog2(NLANE+1);

  logic clk;
  logic rst;
  logic en;
`ifdef FIFO_PI_STREAM_ERR_EN
  logic [1:0] err;
`endif

  fifo_pi_stream_if #(.WIDTH(WIDTH), .NLANE(NLANE), .DEPTH(DEPTH)) bus ();

  fifo_pi_stream #(
    .WIDTH(WIDTH), .NLANE(NLANE), .DEPTH(DEPTH),
    .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .EN(en),
`ifdef FIFO_PI_STREAM_ERR_EN
    .ERR(err),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int peak     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: stored words and words still waiting in the stager, as plain queues.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sq[$];
  logic [1:0]       m_err;
  bit               m_do_zero;
  bit               m_acc;

  function automatic bit m_push();
    return (sq.size() != 0) && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_wready();
    return (sq.size() == 0) || ((sq.size() == 1) && m_push());
  endfunction

  task automatic model_reset();
    mq.delete();
    sq.delete();
    m_err     = '0;
    m_do_zero = 1'b1;
    m_acc     = 1'b0;
  endtask

  task automatic model_step();
    bit push, pop, wr;
    int n;
    logic [WIDTH*NLANE-1:0] di;
    m_acc = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) return;
    m_do_zero = 1'b0;
    push = m_push();
    pop  = bus.READ && (mq.size() != 0);
    wr   = m_wready();
    if (bus.WRITE && !wr)           m_err[0] = 1'b1;
    if (bus.READ && mq.size() == 0) m_err[1] = 1'b1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(sq.pop_front());
    if (bus.WRITE && wr && bus.DI_CNT != 0) begin
      n  = (int'(bus.DI_CNT) > NLANE) ? NLANE : int'(bus.DI_CNT);
      di = bus.DI;
      for (int k = 0; k < n; k++) sq.push_back(di[k*WIDTH +: WIDTH]);
      m_acc = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    if (int'(bus.LEVEL) > peak) peak = int'(bus.LEVEL);
    check("level",  32'(bus.LEVEL),  32'(sz));
    check("empty",  32'(bus.EMPTY),  32'(sz == 0));
    check("full",   32'(bus.FULL),   32'(sz == DEPTH));
    check("afull",  32'(bus.AFULL),  32'(sz >= AFULL_TH));
    check("aempty", 32'(bus.AEMPTY), 32'(sz <= AEMPTY_TH));
    check("wready", 32'(bus.WREADY), 32'(m_wready()));
    if (sz != 0)        check("do",     32'(bus.DO), 32'(mq[0]));
    else if (m_do_zero) check("do_rst", 32'(bus.DO), 32'(0));
`ifdef FIFO_PI_STREAM_ERR_EN
    check("err", 32'(err), 32'(m_err));
`endif
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input int cnt, input int base);
    logic [WIDTH*NLANE-1:0] v;
    for (int k = 0; k < NLANE; k++) v[k*WIDTH +: WIDTH] = WIDTH'(base + k);
    bus.DI     = v;
    bus.DI_CNT = CW'(cnt);
    bus.WRITE  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (m_acc) break;
    end
    check("wr_accept", 32'(m_acc), 32'(1));
    bus.WRITE = 1'b0;
  endtask

  task automatic drain();
    bus.READ = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (bus.EMPTY && sq.size() == 0) break;
    end
    check("drain_empty", 32'(bus.EMPTY), 32'(1));
    bus.READ = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH*NLANE-1:0] rv;
    int rd_bias;
    rst        = 1'b1;
    en         = 1'b1;
    bus.DI     = '0;
    bus.DI_CNT = '0;
    bus.WRITE  = 1'b0;
    bus.READ   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state.
    check("rst_do",     32'(bus.DO),     32'(0));
    check("rst_wready", 32'(bus.WREADY), 32'(1));
    check("rst_aempty", 32'(bus.AEMPTY), 32'(1));

    // One full vector, consumer starts reading one cycle after it sees data.
    peak = 0;
    write_vec(9, 1);
    for (int i = 0; i < 10 && bus.EMPTY; i++) cyc();
    check("t1_nonempty", 32'(bus.EMPTY), 32'(0));
    check("t1_first",    32'(bus.DO),    32'(1));
    cyc();
    bus.READ = 1'b1;
    repeat (9) cyc();
    bus.READ = 1'b0;
    check("t1_empty", 32'(bus.EMPTY), 32'(1));
    check("t1_peak",  32'(peak),      32'(2));

    // Back-to-back 9, 9, 3 with no reads: fills and stalls with two words staged.
    write_vec(9, 16'h100);
    write_vec(9, 16'h200);
    write_vec(3, 16'h300);
    for (int i = 0; i < 30 && int'(bus.LEVEL) != DEPTH; i++) cyc();
    cyc();
    check("t2_level",  32'(bus.LEVEL),  32'(DEPTH));
    check("t2_full",   32'(bus.FULL),   32'(1));
    check("t2_afull",  32'(bus.AFULL),  32'(1));
    check("t2_wready", 32'(bus.WREADY), 32'(0));
    drain();

    // Zero-lane write is a no-op; oversize count is clamped to NLANE.
    bus.WRITE  = 1'b1;
    bus.DI_CNT = '0;
    repeat (2) cyc();
    bus.WRITE = 1'b0;
    check("t3_cnt0_level", 32'(bus.LEVEL), 32'(0));
    write_vec(12, 16'h400);
    repeat (14) cyc();
    check("t3_clamp_level", 32'(bus.LEVEL), 32'(9));
    drain();

    // Reset in the middle of a drain.
    write_vec(9, 16'h500);
    for (int i = 0; i < 20 && int'(bus.LEVEL) != 5; i++) cyc();
    do_reset();
    check("t5_level",  32'(bus.LEVEL),  32'(0));
    check("t5_empty",  32'(bus.EMPTY),  32'(1));
    check("t5_wready", 32'(bus.WREADY), 32'(1));
    check("t5_do",     32'(bus.DO),     32'(0));

    // EN low freezes everything.
    write_vec(3, 16'h600);
    repeat (4) cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.WRITE  = 1'($urandom_range(0, 1));
      bus.READ   = 1'($urandom_range(0, 1));
      bus.DI_CNT = CW'($urandom_range(1, 9));
      cyc();
    end
    check("t5_hold_level", 32'(bus.LEVEL), 32'(3));
    check("t5_hold_do",    32'(bus.DO),    32'(16'h600));
    bus.WRITE = 1'b0;
    en = 1'b1;
    drain();

`ifdef FIFO_PI_STREAM_ERR_EN
    do_reset();
    write_vec(9, 16'h700);
    bus.WRITE  = 1'b1;
    bus.DI_CNT = CW'(2);
    cyc();
    bus.WRITE = 1'b0;
    check("err_ovf", 32'(err), 32'(2'b01));
    bus.READ = 1'b1;
    repeat (15) cyc();
    bus.READ = 1'b0;
    check("err_both", 32'(err), 32'(2'b11));
    repeat (3) cyc();
    check("err_sticky", 32'(err), 32'(2'b11));
    do_reset();
    check("err_clear", 32'(err), 32'(2'b00));
`endif

    // Random traffic, including dropped writes, oversize counts, EN gaps and rare resets.
    rd_bias = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) rd_bias = $urandom_range(10, 90);
      for (int k = 0; k < NLANE; k++) rv[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      rst        = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 9) != 0);
      bus.WRITE  = 1'($urandom_range(0, 1));
      bus.DI     = rv;
      bus.DI_CNT = CW'($urandom_range(0, 15));
      bus.READ   = ($urandom_range(0, 99) < rd_bias);
      cyc();
    end
    rst       = 1'b0;
    en        = 1'b1;
    bus.WRITE = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
